// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe; slave is the adder's view, master the driver's.
// The sat signal only exists when ADD_PIPE_SATURATE_EN is defined.
interface add_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
`ifdef ADD_PIPE_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
`ifdef ADD_PIPE_SATURATE_EN
    input  sat,
`endif
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
`ifdef ADD_PIPE_SATURATE_EN
    output sat,
`endif
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_pipe.sv
// add_pipe: WIDTH-bit add/sub with carry-in, carry chain cut into STAGES registered segments.
// Optional signed saturation of the result when ADD_PIPE_SATURATE_EN is defined.
module add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  add_pipe_if.slave bus
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Stage k registers: partial sum up to segment k, its carry, and the skewed operands.
  logic             r_vld   [STAGES];
  logic             r_carry [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_ovf;

  logic             w_en;
  logic             w_vin    [STAGES];
  logic [WIDTH-1:0] w_op_a   [STAGES];
  logic [WIDTH-1:0] w_op_b   [STAGES];
  logic             w_cin    [STAGES];
  logic [WIDTH-1:0] w_part   [STAGES];
  logic [WIDTH-1:0] w_nsum   [STAGES];
  logic             w_ncarry [STAGES];
  logic [SEG:0]     w_seg;
  logic             w_msb_c;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

`ifdef ADD_PIPE_SATURATE_EN
  logic             r_sat [STAGES];
  logic             w_sat [STAGES];
`endif

  assign w_en          = bus.out_ready | ~r_vld[LAST];
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[LAST];
  assign bus.sum       = r_sum[LAST];
  assign bus.cout      = r_carry[LAST];
  assign bus.ovf       = r_ovf;

  always_comb begin
    w_seg     = '0;
    w_vin[0]  = bus.in_valid;
    w_op_a[0] = bus.a;
    w_op_b[0] = bus.b ^ {WIDTH{bus.sub}};
    w_cin[0]  = bus.cin ^ bus.sub;
    w_part[0] = '0;
`ifdef ADD_PIPE_SATURATE_EN
    w_sat[0]  = bus.sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k]  = r_vld[k-1];
      w_op_a[k] = r_a[k-1];
      w_op_b[k] = r_b[k-1];
      w_cin[k]  = r_carry[k-1];
      w_part[k] = r_sum[k-1];
`ifdef ADD_PIPE_SATURATE_EN
      w_sat[k]  = r_sat[k-1];
`endif
    end
    for (int k = 0; k < STAGES; k++) begin
      w_seg = {1'b0, w_op_a[k][k*SEG +: SEG]} + {1'b0, w_op_b[k][k*SEG +: SEG]}
            + {{SEG{1'b0}}, w_cin[k]};
      w_nsum[k]               = w_part[k];
      w_nsum[k][k*SEG +: SEG] = w_seg[SEG-1:0];
      w_ncarry[k]             = w_seg[SEG];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit, so ovf needs no extra chain tap.
  always_comb begin
    w_msb_c = w_op_a[LAST][WIDTH-1] ^ w_op_b[LAST][WIDTH-1] ^ w_nsum[LAST][WIDTH-1];
    w_ovf   = w_msb_c ^ w_ncarry[LAST];
    w_res   = w_nsum[LAST];
`ifdef ADD_PIPE_SATURATE_EN
    if (w_sat[LAST] && w_ovf) begin
      w_res = w_op_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]   <= 1'b0;
        r_carry[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
`ifdef ADD_PIPE_SATURATE_EN
        r_sat[k]   <= 1'b0;
`endif
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vin[k];
      end
      for (int k = 0; k < LAST; k++) begin
        r_sum[k]   <= w_nsum[k];
        r_carry[k] <= w_ncarry[k];
        r_a[k]     <= w_op_a[k];
        r_b[k]     <= w_op_b[k];
`ifdef ADD_PIPE_SATURATE_EN
        r_sat[k]   <= w_sat[k];
`endif
      end
      // Output registers only move on a real transaction so they keep their last result.
      if (w_vin[LAST]) begin
        r_sum[LAST]   <= w_res;
        r_carry[LAST] <= w_ncarry[LAST];
        r_ovf         <= w_ovf;
      end
    end
  end
endmodule
